// File: rtl/vic_int_arbiter.sv
// vic_int_arbiter: picks one pending interrupt from the collector, presents it to
// the CPU as irq/irq_id, tracks the ack/EOI handshake and returns a one-hot
// clear pulse. The clear is retried while the collector still shows the line
// pending after one edge, which means a new edge arrived with the clear.
// Build option: define VIC_ARB_RR_EN for round-robin selection. When it is
// undefined, the lowest pending index wins.
module vic_int_arbiter #(
  parameter int unsigned INT_NUM = 6,
  parameter int unsigned ID_W    = 3
) (
  input  logic               clk,
  input  logic               rst_x,
  input  logic [INT_NUM-1:0] int_pend,
  input  logic               cpu_ack,
  input  logic               cpu_eoi,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [INT_NUM-1:0] int_clr,
  output logic               busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    SVC  = 3'd2,
    CLR  = 3'd3,
    CHK  = 3'd4
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    win_id;
  logic               pend_cur;
  logic [INT_NUM-1:0] clr_vec;

  // Pending status and one-hot clear for the currently granted line
  always_comb begin
    pend_cur = int_pend[irq_id];
    clr_vec  = INT_NUM'(1) << irq_id;
  end

`ifdef VIC_ARB_RR_EN
  logic [ID_W-1:0] last_id;

  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    return (s >= int'(INT_NUM)) ? s - int'(INT_NUM) : s;
  endfunction

  // Round-robin search starting just after the last fully serviced line
  always_comb begin
    win_id = '0;
    for (int k = int'(INT_NUM); k >= 1; k--) begin
      if (int_pend[wrap_idx(int'(last_id), k)]) begin
        win_id = ID_W'(wrap_idx(int'(last_id), k));
      end
    end
  end

  // Remember the serviced line once its clear has been confirmed
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      last_id <= ID_W'(INT_NUM - 1);
    end else if (state == CHK && !pend_cur) begin
      last_id <= irq_id;
    end
  end
`else
  // Fixed priority: lowest pending index wins
  always_comb begin
    win_id = '0;
    for (int i = int'(INT_NUM) - 1; i >= 0; i--) begin
      if (int_pend[i]) begin
        win_id = ID_W'(i);
      end
    end
  end
`endif

  // Grant / handshake / clear FSM with registered outputs
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state   <= IDLE;
      irq     <= 1'b0;
      irq_id  <= '0;
      int_clr <= '0;
      busy    <= 1'b0;
    end else begin
      int_clr <= '0;
      case (state)
        IDLE: begin
          if (|int_pend) begin
            irq_id <= win_id;
            irq    <= 1'b1;
            busy   <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (cpu_ack) begin
            irq   <= 1'b0;
            state <= SVC;
          end else if (!pend_cur) begin
            irq   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SVC: begin
          if (cpu_eoi) begin
            int_clr <= clr_vec;
            state   <= CLR;
          end
        end
        CLR: begin
          state <= CHK;
        end
        CHK: begin
          if (pend_cur) begin
            int_clr <= clr_vec;
            state   <= CLR;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          irq   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vic_int_arbiter.sv
// Self-checking bench for vic_int_arbiter: directed handshake scenarios followed
// by randomized services against a behavioural collector/CPU reference.
module tb_vic_int_arbiter;

`ifdef VIC_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_x;
  logic [5:0] int_pend;
  logic       cpu_ack;
  logic       cpu_eoi;
  logic       irq;
  logic [2:0] irq_id;
  logic [5:0] int_clr;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  vic_int_arbiter #(.INT_NUM(6), .ID_W(3)) dut (
    .clk      (clk),
    .rst_x    (rst_x),
    .int_pend (int_pend),
    .cpu_ack  (cpu_ack),
    .cpu_eoi  (cpu_eoi),
    .irq      (irq),
    .irq_id   (irq_id),
    .int_clr  (int_clr),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected winner: lowest index, or first pending after 'last' in round-robin
  function automatic int pick(input logic [5:0] p, input int last);
    for (int k = 1; k <= 6; k++) begin
      int j;
      j = RR ? (last + k) % 6 : k - 1;
      if (p[j]) return j;
    end
    return 0;
  endfunction

  function automatic logic [5:0] edges();
    return 6'($urandom & $urandom & $urandom);
  endfunction

  // One complete service from IDLE with int_pend == full already driven
  task automatic grant_cycle(input logic [5:0] full, input int exp_id,
                             input bit restore, input string tag);
    logic [5:0] oh;
    oh = 6'(1) << exp_id;
    tick();
    chk({tag, "_irq"}, 32'(irq), 1);
    chk({tag, "_id"}, 32'(irq_id), exp_id);
    chk({tag, "_busy"}, 32'(busy), 1);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk({tag, "_irq_ack"}, 32'(irq), 0);
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    chk({tag, "_clr"}, 32'(int_clr), 32'(oh));
    int_pend = full & ~oh;
    tick();
    chk({tag, "_clr_one"}, 32'(int_clr), 0);
    tick();
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_idle_irq"}, 32'(irq), 0);
    if (restore) int_pend = full;
  endtask

  task automatic do_reset();
    rst_x = 1'b0;
    tick();
    rst_x = 1'b1;
  endtask

  initial begin
    int exp2 [3];
    int last;
    int eid;
    int w;
    bit done;
    logic [5:0] oh;

    rst_x    = 1'b0;
    int_pend = '0;
    cpu_ack  = 1'b0;
    cpu_eoi  = 1'b0;
    tick();
    tick();
    chk("rst_irq", 32'(irq), 0);
    chk("rst_id", 32'(irq_id), 0);
    chk("rst_clr", 32'(int_clr), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_x = 1'b1;

    // 1: single line 2, full handshake, pend falls with the clear
    int_pend = 6'b000100;
    grant_cycle(6'b000100, 2, 1'b0, "t1");

    // 2: lines 2 and 5 held, line 2 re-pended after each clear
    do_reset();
    exp2 = RR ? '{2, 5, 2} : '{2, 2, 2};
    int_pend = 6'b100100;
    for (int i = 0; i < 3; i++) grant_cycle(6'b100100, exp2[i], 1'b1, $sformatf("t2_%0d", i));

    // 3: withdraw in REQ
    int_pend = 6'b001000;
    tick();
    chk("t3_irq", 32'(irq), 1);
    chk("t3_id", 32'(irq_id), 3);
    int_pend = '0;
    tick();
    chk("t3_irq_drop", 32'(irq), 0);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_clr", 32'(int_clr), 0);
    tick();
    chk("t3_clr_later", 32'(int_clr), 0);
    chk("t3_irq_later", 32'(irq), 0);

    // 4: lost clear on line 1 forces a retry two cycles later
    int_pend = 6'b000010;
    tick();
    chk("t4_id", 32'(irq_id), 1);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    chk("t4_clr1", 32'(int_clr), 32'(6'b000010));
    tick();
    chk("t4_chk", 32'(int_clr), 0);
    tick();
    chk("t4_clr2", 32'(int_clr), 32'(6'b000010));
    int_pend = '0;
    tick();
    chk("t4_chk2", 32'(int_clr), 0);
    tick();
    chk("t4_idle", 32'(busy), 0);

    // 5: spurious EOI/ACK and simultaneous ACK+EOI
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    chk("t5_idle_eoi", 32'(busy), 0);
    int_pend = 6'b010000;
    tick();
    chk("t5_id", 32'(irq_id), 4);
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    chk("t5_req_eoi_irq", 32'(irq), 1);
    chk("t5_req_eoi_clr", 32'(int_clr), 0);
    cpu_ack = 1'b1;
    cpu_eoi = 1'b1;
    tick();
    cpu_ack = 1'b0;
    cpu_eoi = 1'b0;
    chk("t5_both_irq", 32'(irq), 0);
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("t5_svc_ack_clr", 32'(int_clr), 0);
    chk("t5_svc_ack_busy", 32'(busy), 1);
    tick();
    chk("t5_svc_wait", 32'(int_clr), 0);
    cpu_eoi = 1'b1;
    tick();
    cpu_eoi = 1'b0;
    chk("t5_clr", 32'(int_clr), 32'(6'b010000));
    int_pend = '0;
    tick();
    tick();
    chk("t5_idle", 32'(busy), 0);

    // 6: asynchronous reset while in SVC, then re-arbitration
    int_pend = 6'b001000;
    tick();
    cpu_ack = 1'b1;
    tick();
    cpu_ack = 1'b0;
    chk("t6_svc_id", 32'(irq_id), 3);
    chk("t6_svc_busy", 32'(busy), 1);
    #2;
    rst_x = 1'b0;
    #1;
    chk("t6_arst_irq", 32'(irq), 0);
    chk("t6_arst_id", 32'(irq_id), 0);
    chk("t6_arst_clr", 32'(int_clr), 0);
    chk("t6_arst_busy", 32'(busy), 0);
    tick();
    rst_x = 1'b1;
    grant_cycle(6'b001000, 3, 1'b0, "t6_re");

    // Randomized services against the collector/CPU reference
    do_reset();
    int_pend = '0;
    last = 5;
    for (int t = 0; t < 40; t++) begin
      if (int_pend == 6'b0) int_pend = 6'(1 << $urandom_range(0, 5)) | edges();
      eid = pick(int_pend, last);
      oh  = 6'(1) << eid;
      tick();
      chk("r_irq", 32'(irq), 1);
      chk("r_id", 32'(irq_id), eid);
      int_pend |= edges();
      w = $urandom_range(0, 3);
      for (int i = 0; i < w; i++) begin
        cpu_eoi = 1'($urandom_range(0, 1));
        tick();
        cpu_eoi = 1'b0;
        chk("r_req_hold", 32'(irq), 1);
        int_pend |= edges();
      end
      cpu_ack = 1'b1;
      cpu_eoi = 1'($urandom_range(0, 1));
      tick();
      cpu_ack = 1'b0;
      cpu_eoi = 1'b0;
      chk("r_ack_irq", 32'(irq), 0);
      int_pend |= edges();
      w = $urandom_range(0, 3);
      for (int i = 0; i < w; i++) begin
        cpu_ack = 1'($urandom_range(0, 1));
        tick();
        cpu_ack = 1'b0;
        chk("r_svc_clr", 32'(int_clr), 0);
        chk("r_svc_id", 32'(irq_id), eid);
        int_pend |= edges();
      end
      cpu_eoi = 1'b1;
      tick();
      cpu_eoi = 1'b0;
      chk("r_clr", 32'(int_clr), 32'(oh));
      done = 1'b0;
      for (int r = 0; r < 16 && !done; r++) begin
        int_pend = (int_pend & ~oh) | edges();
        tick();
        chk("r_chk", 32'(int_clr), 0);
        tick();
        if (int_pend[eid]) begin
          chk("r_retry", 32'(int_clr), 32'(oh));
        end else begin
          chk("r_idle_busy", 32'(busy), 0);
          chk("r_idle_clr", 32'(int_clr), 0);
          done = 1'b1;
        end
      end
      if (!done) begin
        n_cmp++;
        n_bad++;
        $error("FAIL r_retry_bound: observed no release expected release within 16 retries");
      end
      last = eid;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
